// File: rtl/booth_arith_pkg.sv
// Shared arithmetic package for the booth multiplier / divider pair.
// Provides the sequencer state encoding, the default operand width and
// two's-complement helpers sized for the default width.
package booth_arith_pkg;

  localparam int N_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Two's negate at product width.
  function automatic logic [2*N_DEF-1:0] neg(input logic [2*N_DEF-1:0] x);
    return ~x + (2*N_DEF)'(1);
  endfunction

  // Magnitude as unsigned. The most-negative value maps to 2^(w-1),
  // which is representable because the result is read unsigned.
  function automatic logic [2*N_DEF-1:0] abs_u(input logic [2*N_DEF-1:0] x);
    return x[2*N_DEF-1] ? neg(x) : x;
  endfunction

endpackage

// File: rtl/booth_divider_if.sv
// Start/valid handshake bundle for booth_divider.
//   master: start, A (2N dividend), D (N divisor) out; results in.
//   slave : the divider side.
interface booth_divider_if #(parameter int N = booth_arith_pkg::N_DEF);
  logic           start;
  logic [2*N-1:0] A;
  logic [N-1:0]   D;
  logic           busy;
  logic           valid;
  logic [2*N-1:0] Q;
  logic [N-1:0]   R;
  logic           div0;
  logic           ovf;

  modport master (output start, A, D, input  busy, valid, Q, R, div0, ovf);
  modport slave  (input  start, A, D, output busy, valid, Q, R, div0, ovf);
endinterface

// File: rtl/booth_divider_div_step.sv
// One combinational restoring-division step.
//   p     : current partial remainder (N+1 bits)
//   din   : next dividend bit shifted in
//   dm    : divisor magnitude
//   p_nxt : partial remainder after the step
//   q     : quotient bit produced
module div_step #(parameter int N = 4) (
  input  logic [N:0]   p,
  input  logic         din,
  input  logic [N-1:0] dm,
  output logic [N:0]   p_nxt,
  output logic         q
);
  logic [N+1:0] sh, diff;

  // One extra bit so the sign of the trial subtraction is the borrow.
  assign sh    = {p, din};
  assign diff  = sh - {2'b00, dm};
  assign q     = ~diff[N+1];
  assign p_nxt = q ? diff[N:0] : sh[N:0];
endmodule

// File: rtl/booth_divider.sv
// Sequential signed divider, companion of the booth multiplier.
//   clk   : rising-edge clock
//   rst   : async active-low reset
//   bus   : slave side of booth_divider_if (start/A/D in; busy/valid/Q/R/div0/ovf out)
// Divides magnitudes MSB first, one restoring step per cycle over 2N cycles,
// then applies signs in a single fix-up cycle. Quotient truncates toward
// zero; remainder carries the dividend's sign.
module booth_divider
  import booth_arith_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic            clk,
  input  logic            rst,
  booth_divider_if.slave  bus
);
  localparam int W  = 2 * N;
  localparam int CW = $clog2(W);

  state_t          state;
  logic            sa, sd, ovf_p;
  logic [W-1:0]    m;          // dividend magnitude shifting out / quotient shifting in
  logic [N-1:0]    dm;
  logic [N:0]      p;
  logic [CW-1:0]   cnt;
  logic            busy_r, valid_r, div0_r, ovf_r;
  logic [W-1:0]    q_r;
  logic [N-1:0]    r_r;

  logic [W-1:0]    a_abs;
  logic [N-1:0]    d_abs;
  logic [N:0]      p_nxt;
  logic            qb;

  assign a_abs = bus.A[W-1] ? ~bus.A + W'(1) : bus.A;
  assign d_abs = bus.D[N-1] ? ~bus.D + N'(1) : bus.D;

  div_step #(.N(N)) u_step (
    .p     (p),
    .din   (m[W-1]),
    .dm    (dm),
    .p_nxt (p_nxt),
    .q     (qb)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      sa      <= 1'b0;
      sd      <= 1'b0;
      ovf_p   <= 1'b0;
      m       <= '0;
      dm      <= '0;
      p       <= '0;
      cnt     <= '0;
      busy_r  <= 1'b0;
      valid_r <= 1'b0;
      div0_r  <= 1'b0;
      ovf_r   <= 1'b0;
      q_r     <= '0;
      r_r     <= '0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          sa      <= bus.A[W-1];
          sd      <= bus.D[N-1];
          m       <= a_abs;
          dm      <= d_abs;
          p       <= '0;
          cnt     <= '0;
          busy_r  <= 1'b1;
          valid_r <= 1'b0;
          ovf_r   <= 1'b0;
          // Only most-negative / -1 overflows; remember it for the fix-up.
          ovf_p   <= (bus.A == {1'b1, {(W-1){1'b0}}}) && (bus.D == '1);
          if (bus.D == '0) begin
            div0_r <= 1'b1;
            q_r    <= '0;
            r_r    <= '0;
            state  <= DONE;
          end else begin
            div0_r <= 1'b0;
            state  <= CALC;
          end
        end
        CALC: begin
          p   <= p_nxt;
          m   <= {m[W-2:0], qb};
          cnt <= cnt + CW'(1);
          if (cnt == CW'(W - 1)) state <= FIX;
        end
        FIX: begin
          // Overflow case falls out naturally: 2^(W-1) reads as -2^(W-1).
          q_r   <= (sa ^ sd) ? ~m + W'(1) : m;
          r_r   <= sa ? ~p[N-1:0] + N'(1) : p[N-1:0];
          ovf_r <= ovf_p;
          state <= DONE;
        end
        DONE: begin
          valid_r <= 1'b1;
          busy_r  <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy  = busy_r;
  assign bus.valid = valid_r;
  assign bus.Q     = q_r;
  assign bus.R     = r_r;
  assign bus.div0  = div0_r;
  assign bus.ovf   = ovf_r;
endmodule

// File: tb/tb_booth_divider.sv
// Directed + randomized bench for booth_divider with a result scoreboard.
module tb_booth_divider;
  import booth_arith_pkg::*;

  localparam int N = N_DEF;
  localparam int W = 2 * N;

  typedef struct packed {
    logic [W-1:0] q;
    logic [N-1:0] r;
    logic         d0;
    logic         ov;
    logic [7:0]   lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  booth_divider_if #(.N(N)) bus ();
  booth_divider #(.N(N)) dut (.clk(clk), .rst(rst), .bus(bus));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   tests = 0;
  int   fails = 0;
  int   e0    = 0;
  exp_t sb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: SV integer division truncates toward zero and % follows the dividend.
  task automatic push_model(input logic [W-1:0] a, input logic [N-1:0] d);
    exp_t e;
    int ai, di, qi, ri;
    ai = int'($signed(a));
    di = int'($signed(d));
    if (di == 0) begin
      e.q = '0; e.r = '0; e.d0 = 1'b1; e.ov = 1'b0; e.lat = 8'd1;
    end else begin
      qi = ai / di;
      ri = ai % di;
      e.q = qi[W-1:0]; e.r = ri[N-1:0]; e.d0 = 1'b0;
      e.ov = (ai == -(1 << (W - 1))) && (di == -1);
      e.lat = 8'(W + 2);
    end
    sb.push_back(e);
  endtask

  task automatic do_start(input logic [W-1:0] a, input logic [N-1:0] d);
    @(negedge clk);
    bus.start = 1'b1; bus.A = a; bus.D = d;
    @(posedge clk); #1;
    bus.start = 1'b0;
    e0 = cyc;
  endtask

  task automatic finish_op(input string tag);
    exp_t e;
    while (bus.valid !== 1'b1 && (cyc - e0) < 40) begin
      @(posedge clk); #1;
    end
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk({tag, "_lat"},  32'(cyc - e0), 32'(e.lat));
      chk({tag, "_q"},    32'(bus.Q),    32'(e.q));
      chk({tag, "_r"},    32'(bus.R),    32'(e.r));
      chk({tag, "_div0"}, 32'(bus.div0), 32'(e.d0));
      chk({tag, "_ovf"},  32'(bus.ovf),  32'(e.ov));
      chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    end
  endtask

  task automatic run(input string tag, input logic [W-1:0] a, input logic [N-1:0] d);
    push_model(a, d);
    do_start(a, d);
    finish_op(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [W-1:0] a;
    logic [N-1:0] d, x, y;
    logic [W-1:0] prod;

    rst = 1'b0; bus.start = 1'b0; bus.A = '0; bus.D = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy",  32'(bus.busy),  32'd0);
    chk("rst_valid", 32'(bus.valid), 32'd0);
    chk("rst_q",     32'(bus.Q),     32'd0);
    chk("rst_r",     32'(bus.R),     32'd0);
    chk("rst_flags", 32'({bus.div0, bus.ovf}), 32'd0);
    @(negedge clk); rst = 1'b1;

    // 35/7 with a stray start at E0+3 that must be ignored.
    push_model(8'd35, 4'd7);
    do_start(8'd35, 4'd7);
    chk("e0_busy",  32'(bus.busy),  32'd1);
    chk("e0_valid", 32'(bus.valid), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    bus.start = 1'b1; bus.A = 8'd99; bus.D = 4'd3;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("ign_busy", 32'(bus.busy), 32'd1);
    finish_op("p35_7");

    // Results hold until the next accepted start.
    repeat (3) @(posedge clk);
    #1;
    chk("hold_valid", 32'(bus.valid), 32'd1);
    chk("hold_q",     32'(bus.Q),     32'd5);
    push_model(-8'sd24, 4'd6);
    do_start(-8'sd24, 4'd6);
    chk("next_valid_drop", 32'(bus.valid), 32'd0);
    chk("next_q_kept",     32'(bus.Q),     32'd5);
    finish_op("m24_6");

    run("m20_6",  -8'sd20, 4'd6);
    run("p35_m4",  8'd35,  -4'sd4);
    run("m7_m8",  -8'sd7,  -4'sd8);
    run("m128_m1", 8'h80,  -4'sd1);
    run("p127_1",  8'd127,  4'd1);

    push_model(8'd10, 4'd0);
    do_start(8'd10, 4'd0);
    chk("d0_e0_busy", 32'(bus.busy), 32'd1);
    finish_op("div0");

    // Async reset mid-CALC clears everything before the next edge.
    do_start(8'd35, 4'd7);
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("arst_busy",  32'(bus.busy),  32'd0);
    chk("arst_valid", 32'(bus.valid), 32'd0);
    chk("arst_q",     32'(bus.Q),     32'd0);
    chk("arst_r",     32'(bus.R),     32'd0);
    chk("arst_flags", 32'({bus.div0, bus.ovf}), 32'd0);
    @(negedge clk); rst = 1'b1;
    run("post_rst", -8'sd20, 4'd6);

    // Multiplier round-trip: (x*y)/y must return x with zero remainder.
    for (int i = 0; i < 6; i++) begin
      x = 4'($urandom_range(0, 15));
      y = 4'($urandom_range(1, 15));
      prod = 8'($signed(x) * $signed(y));
      sb.push_back('{q: {{N{x[N-1]}}, x}, r: '0, d0: 1'b0, ov: 1'b0, lat: 8'(W + 2)});
      do_start(prod, y);
      finish_op($sformatf("rt%0d", i));
    end

    for (int i = 0; i < 8; i++) begin
      a = 8'($urandom_range(0, 255));
      d = 4'($urandom_range(0, 15));
      run($sformatf("rnd%0d", i), a, d);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/booth_divider.md
Name: booth_divider

Overview:
- Sequential signed divider; the inverse companion of the booth multiplier.
- Accepts a 2N-bit signed dividend (multiplier product width) and an N-bit signed divisor (multiplier operand width).
- Returns quotient and remainder using the same start/valid handshake as the multiplier.
- Used to check multiplier products round-trip and as the datapath divide unit.

Parameters:
- N, 4, operand width; dividend and quotient are 2N bits, divisor and remainder are N bits.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only while idle.
- A  input  2N  signed dividend; captured on the accepted start edge.
- D  input  N  signed divisor; captured on the accepted start edge.
- busy  output  1  high from the accepted start until results are valid.
- valid  output  1  results stable.
- Q  output  2N  signed quotient.
- R  output  N  signed remainder.
- div0  output  1  divisor was zero.
- ovf  output  1  quotient not representable (most-negative A divided by -1).

Behaviour:
- Reset (rst=0, async): state=IDLE; busy, valid, div0, ovf, Q, R, counter and all internal registers = 0. Reset mid-operation aborts immediately; no result is produced.
- States: IDLE, CALC, FIX, DONE.
- IDLE, start=1 at edge E0:
  - Capture sA=A[2N-1], sD=D[N-1], |A| (2N-bit unsigned, so -2^(2N-1) is representable), |D| (N-bit unsigned).
  - Clear partial remainder P (N+1 bits) and counter. busy=1. valid=0, div0=0, ovf=0.
  - Go to CALC, or to DONE if D==0.
- CALC, one quotient bit per cycle, 2N cycles, MSB first:
  - {P,M} shifted left by 1.
  - T = P - |D|. If T>=0: P=T, quotient LSB=1; else quotient LSB=0 (restoring).
  - Counter increments; after the 2N-th cycle go to FIX.
- FIX, one cycle:
  - Q = (sA^sD) ? -M : M, modulo 2^2N.
  - R = sA ? -P[N-1:0] : P[N-1:0].
  - ovf=1 iff A==-2^(2N-1) and D==-1; Q then wraps to -2^(2N-1).
  - Go to DONE.
- Division by zero: D==0 goes IDLE→DONE at E0 with Q=0, R=0, div0=1.
- DONE: valid=1, busy=0, Q/R/div0/ovf held. Next cycle go to IDLE; valid, Q, R and flags stay held until the next accepted start.
- Latency:
  - Normal: start sampled at E0, valid rises at E0+2N+2 (10 cycles for N=4).
  - div0: valid rises at E0+1.
- Arithmetic: truncation toward zero. Remainder takes the sign of the dividend (or is 0). |R| < |D|. A == Q*D + R whenever ovf=0 and div0=0.
- start while busy: ignored; operands are not re-captured. start held high continuously: a new operation is accepted on each return to IDLE.
- valid falls on the edge that accepts the next start; Q/R keep their old values until FIX.
- A/D changes while busy have no effect.

Decomposition:
- Package booth_arith_pkg:
  - state enum {IDLE, CALC, FIX, DONE}
  - width constant N_DEF=4
  - function abs_u (two's-complement magnitude)
  - function neg (two's negate)
  - Shared with the multiplier.
- One sub-module is natural: div_step, a combinational single restoring step. Inputs P, next dividend bit, |D|. Outputs new P and quotient bit.
- FSM, counter and sign fix-up live in the top.

Test Plan:
- Reset with rst=0 for 2 cycles, then start A=35, D=7 → at E0+10: valid=1, Q=5, R=0, div0=0, ovf=0 (round-trip of multiplier 5*7).
- A=-24, D=6 → Q=-4, R=0. A=-20, D=6 → Q=-3, R=-2. A=35, D=-4 → Q=-8, R=3. A=-7, D=-8 → Q=0, R=-7.
- A=-128, D=-1 → valid at E0+10, ovf=1, Q=-128, R=0. A=127, D=1 → Q=127, ovf=0.
- A=10, D=0 → valid at E0+1, div0=1, Q=0, R=0, busy never high beyond E0 cycle.
- start pulsed again at E0+3 with A=99, D=3 → ignored; result is still for the first operands. Outputs hold after valid until the next start; valid drops on that start edge.
- Assert rst=0 at E0+4 mid-CALC → all outputs 0 asynchronously, before the next clock edge. After release, start A=-20, D=6 → correct result Q=-3, R=-2 at full latency.
